decode_stage: RTL and testbench



---
 rtl/rv32i_types.sv | 50 +++++
 rtl/rv32i_decoder.sv | 60 ++++++
 rtl/decode_stage.sv | 86 ++++++++
 tb/tb_decode_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I decode types: micro-op layout, immediate formats, base opcodes.
// Purely declarative; no state, no timing.
package rv32i_types;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        is_branch;
        logic        is_jump;
        logic        pred;
        logic        illegal;
    } decoded_uop_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
            IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: instruction/pc/prediction to micro-op, zero latency.
// No flow control; the caller decides whether the result is captured.
module rv32i_decoder
    import rv32i_types::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  pc,
    input  logic         pred,
    output decoded_uop_t uop
);

    logic [6:0] opc;
    imm_fmt_t   fmt;
    logic       legal;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       no_rd;

    assign opc = instr[6:0];

    always_comb begin
        fmt      = IMM_NONE;
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        no_rd    = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin fmt = IMM_U; uses_rs1 = 1'b0; end
            OPC_JAL:            begin fmt = IMM_J; uses_rs1 = 1'b0; end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = IMM_I;
            OPC_STORE:  begin fmt = IMM_S; uses_rs2 = 1'b1; no_rd = 1'b1; end
            OPC_BRANCH: begin fmt = IMM_B; uses_rs2 = 1'b1; no_rd = 1'b1; end
            OPC_OP:     uses_rs2 = 1'b1;
            default:    begin legal = 1'b0; uses_rs1 = 1'b0; end
        endcase
    end

    always_comb begin
        uop           = '0;
        uop.pc        = pc;
        uop.opcode    = opc;
        uop.funct3    = instr[14:12];
        uop.funct7    = instr[31:25];
        uop.rd        = instr[11:7];
        uop.rs1       = instr[19:15];
        uop.rs2       = instr[24:20];
        uop.imm       = gen_imm(instr, fmt);
        // Shift-immediates carry only the shamt; funct7 stays in its own field.
        if (opc == OPC_OP_IMM && instr[13:12] == 2'b01)
            uop.imm   = {27'b0, instr[24:20]};
        uop.uses_rs1  = uses_rs1;
        uop.uses_rs2  = uses_rs2;
        uop.writes_rd = legal && !no_rd && (instr[11:7] != 5'd0);
        uop.is_branch = (opc == OPC_BRANCH);
        uop.is_jump   = (opc == OPC_JAL) || (opc == OPC_JALR);
        uop.pred      = pred && (opc == OPC_BRANCH);
        uop.illegal   = !legal;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetch output into a DEPTH-entry micro-op FIFO; 1-cycle latency.
// stall_out asserts purely from a full count; flush empties the buffer next cycle.
module decode_stage
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instr_in,
    input  logic         instr_valid,
    input  logic [31:0]  pc_in,
    input  logic         pred_in,
    input  logic         flush,
    input  logic         out_ready,
    output logic         stall_out,
    output logic         out_valid,
    output decoded_uop_t out_uop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    decoded_uop_t  mem_q [DEPTH];
    decoded_uop_t  mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    decoded_uop_t  dec_uop;
    logic          push;
    logic          pop;

    rv32i_decoder u_dec (
        .instr (instr_in),
        .pc    (pc_in),
        .pred  (pred_in),
        .uop   (dec_uop)
    );

    assign out_valid = (count_q != '0);
    assign stall_out = (count_q == FULL);
    assign out_uop   = mem_q[head_q];

    always_comb begin
        push    = instr_valid && !stall_out && !flush;
        pop     = out_valid && out_ready && !flush;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = dec_uop;
                tail_d        = tail_q + PW'(1);
            end
            if (pop)
                head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboarded bench for decode_stage: directed instructions with hand-derived expectations.
module tb_decode_stage;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  instr_in = '0;
    logic         instr_valid = 1'b0;
    logic [31:0]  pc_in = '0;
    logic         pred_in = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic         stall_out;
    logic         out_valid;
    decoded_uop_t out_uop;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [6:0]  fl; // uses_rs1 uses_rs2 writes_rd is_branch is_jump pred illegal
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    decode_stage #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .pc_in       (pc_in),
        .pred_in     (pred_in),
        .flush       (flush),
        .out_ready   (out_ready),
        .stall_out   (stall_out),
        .out_valid   (out_valid),
        .out_uop     (out_uop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic p,
                         input logic accept, input logic [31:0] imm, input logic [6:0] fl);
        exp_t e;
        instr_in    = ins;
        pc_in       = pc;
        pred_in     = p;
        instr_valid = 1'b1;
        if (accept) begin
            e = '{pc: pc, f7: ins[31:25], rd: ins[11:7], rs1: ins[19:15], rs2: ins[24:20],
                  imm: imm, fl: fl};
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        pred_in     = 1'b0;
    endtask

    // Monitor: compares every accepted head against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t act;
        exp_t exp;
        if (rst || flush) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            act = '{pc: out_uop.pc, f7: out_uop.funct7, rd: out_uop.rd, rs1: out_uop.rs1,
                    rs2: out_uop.rs2, imm: out_uop.imm,
                    fl: {out_uop.uses_rs1, out_uop.uses_rs2, out_uop.writes_rd,
                         out_uop.is_branch, out_uop.is_jump, out_uop.pred, out_uop.illegal}};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc %h with no entry expected", out_uop.pc);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL uop_pc_%h: got %h expected %h", exp.pc, act, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_stall", {31'b0, stall_out}, 32'd0);
        chk("reset_uop_zero", {31'b0, |out_uop}, 32'd0);
        rst = 1'b0;

        // addi x1,x0,5: one-cycle latency, then empty
        out_ready = 1'b1;
        drive(32'h00500093, 32'h1eceb000, 1'b0, 1'b1, 32'd5, 7'b1010000);
        tick();
        idle();
        chk("addi_out_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_stall", {31'b0, stall_out}, 32'd0);
        tick();
        chk("addi_drained", {31'b0, out_valid}, 32'd0);

        // Fill, ignore a third instruction while full, pop one
        out_ready = 1'b0;
        drive(32'h00a00113, 32'h00000100, 1'b0, 1'b1, 32'd10, 7'b1010000);
        tick();
        drive(32'h002081b3, 32'h00000104, 1'b0, 1'b1, 32'd0, 7'b1110000);
        tick();
        chk("full_stall", {31'b0, stall_out}, 32'd1);
        drive(32'h00c00213, 32'h00000108, 1'b0, 1'b0, 32'd0, 7'b0);
        tick();
        idle();
        chk("ignored_stall", {31'b0, stall_out}, 32'd1);
        chk("ignored_head_pc", out_uop.pc, 32'h00000100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after_pop_stall", {31'b0, stall_out}, 32'd0);
        chk("after_pop_head_pc", out_uop.pc, 32'h00000104);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fill_drained", {31'b0, out_valid}, 32'd0);

        // beq x0,x0,-4 predicted taken; jal x0,8 with pred forced off
        out_ready = 1'b1;
        drive(32'hfe000ee3, 32'h00000200, 1'b1, 1'b1, 32'hfffffffc, 7'b1101010);
        tick();
        drive(32'h0080006f, 32'h00000204, 1'b1, 1'b1, 32'd8, 7'b0000100);
        tick();
        idle();
        tick();
        chk("branch_drained", {31'b0, out_valid}, 32'd0);

        // Flush while full with push and pop requested
        out_ready = 1'b0;
        drive(32'h123452b7, 32'h00000300, 1'b0, 1'b1, 32'h12345000, 7'b0010000);
        tick();
        drive(32'h00100393, 32'h00000304, 1'b0, 1'b1, 32'd1, 7'b1010000);
        tick();
        chk("preflush_stall", {31'b0, stall_out}, 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(32'h00200413, 32'h00000308, 1'b0, 1'b0, 32'd0, 7'b0);
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        idle();
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_stall", {31'b0, stall_out}, 32'd0);
        drive(32'h00001317, 32'h00000310, 1'b0, 1'b1, 32'h00001000, 7'b0010000);
        tick();
        idle();
        chk("postflush_valid", {31'b0, out_valid}, 32'd1);
        chk("postflush_stall", {31'b0, stall_out}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("postflush_sole", {31'b0, out_valid}, 32'd0);

        // count==1 with simultaneous push/pop across pointer wrap
        drive(32'hfff00393, 32'h00000400, 1'b0, 1'b1, 32'hffffffff, 7'b1010000);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ins;
            ins = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            drive(ins, 32'h404 + 32'(4 * i), 1'b0, 1'b1, 32'(i), 7'b1010000);
            tick();
            chk($sformatf("steady_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("steady_stall_%0d", i), {31'b0, stall_out}, 32'd0);
        end
        idle();
        tick();
        chk("steady_drained", {31'b0, out_valid}, 32'd0);

        // slli / srai shamt handling, then an illegal custom-0 opcode
        drive(32'h00309093, 32'h00000500, 1'b0, 1'b1, 32'd3, 7'b1010000);
        tick();
        drive(32'h40415113, 32'h00000504, 1'b0, 1'b1, 32'd4, 7'b1010000);
        tick();
        drive(32'h0000000b, 32'h00000508, 1'b1, 1'b1, 32'd0, 7'b0000001);
        tick();
        idle();
        tick();
        chk("illegal_drained", {31'b0, out_valid}, 32'd0);

        // Reset mid-stream with two entries buffered
        out_ready = 1'b0;
        drive(32'h00500093, 32'h00000600, 1'b0, 1'b1, 32'd5, 7'b1010000);
        tick();
        drive(32'h00a00113, 32'h00000604, 1'b0, 1'b1, 32'd10, 7'b1010000);
        tick();
        idle();
        chk("prerst_valid", {31'b0, out_valid}, 32'd1);
        chk("prerst_stall", {31'b0, stall_out}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_stall", {31'b0, stall_out}, 32'd0);
        chk("midrst_uop_zero", {31'b0, |out_uop}, 32'd0);
        tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
